// File: rtl/seletor_pkg.sv
// Shared types and helpers for the stocked product selector.
// Holds the FSM state enum, the legacy price/valid default map and an
// all-ones code helper used as the "no product" marker on codeOut.
package seletor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_OFFER,
        ST_VEND,
        ST_REJECT
    } state_t;

    // Price is carried 8 bits wide here; each user truncates or widens to PRICE_W.
    typedef struct packed {
        logic       valid;
        logic [7:0] price;
    } slot_dflt_t;

    // Legacy keypad map; any code outside it (including codes >= 16) is invalid.
    function automatic slot_dflt_t default_slot(input logic [31:0] code);
        slot_dflt_t s;
        s.valid = 1'b0;
        s.price = 8'd0;
        case (code)
            32'd0:  begin s.valid = 1'b1; s.price = 8'd2; end
            32'd4:  begin s.valid = 1'b1; s.price = 8'd6; end
            32'd5:  begin s.valid = 1'b1; s.price = 8'd1; end
            32'd8:  begin s.valid = 1'b1; s.price = 8'd1; end
            32'd9:  begin s.valid = 1'b1; s.price = 8'd3; end
            32'd10: begin s.valid = 1'b1; s.price = 8'd5; end
            32'd11: begin s.valid = 1'b1; s.price = 8'd4; end
            32'd12: begin s.valid = 1'b1; s.price = 8'd2; end
            32'd13: begin s.valid = 1'b1; s.price = 8'd5; end
            default: ;
        endcase
        return s;
    endfunction

    // Low w bits set; callers cast down to their code width.
    function automatic logic [31:0] invalid_code(input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seletor_tabela.sv
// Slot tables: valid flag, price and stock per slot code, loaded from the
// default map on reset. Ports: write port (wr_*), stock decrement port
// (dec_*, saturates at zero), combinational read at rd_addr (rd_*).
module seletor_tabela
    import seletor_pkg::*;
#(
    parameter int CODE_W     = 4,
    parameter int PRICE_W    = 3,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [CODE_W-1:0]  wr_addr,
    input  logic               wr_valid,
    input  logic [PRICE_W-1:0] wr_price,
    input  logic [STOCK_W-1:0] wr_stock,
    input  logic               dec_en,
    input  logic [CODE_W-1:0]  dec_addr,
    input  logic [CODE_W-1:0]  rd_addr,
    output logic               rd_valid,
    output logic [PRICE_W-1:0] rd_price,
    output logic [STOCK_W-1:0] rd_stock
);

    localparam int NSLOT = 2**CODE_W;

    logic               valid_q [NSLOT];
    logic [PRICE_W-1:0] price_q [NSLOT];
    logic [STOCK_W-1:0] stock_q [NSLOT];

    logic               dflt_valid [NSLOT];
    logic [PRICE_W-1:0] dflt_price [NSLOT];

    for (genvar g = 0; g < NSLOT; g++) begin : g_dflt
        localparam slot_dflt_t D = default_slot(32'(g));
        assign dflt_valid[g] = D.valid;
        assign dflt_price[g] = PRICE_W'(D.price);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                valid_q[i] <= dflt_valid[i];
                price_q[i] <= dflt_price[i];
                stock_q[i] <= dflt_valid[i] ? STOCK_W'(INIT_STOCK) : '0;
            end
        end else begin
            // Writes only happen in IDLE and decrements only in VEND, so they never collide.
            if (wr_en) begin
                valid_q[wr_addr] <= wr_valid;
                price_q[wr_addr] <= wr_price;
                stock_q[wr_addr] <= wr_stock;
            end
            if (dec_en && (stock_q[dec_addr] != '0)) begin
                stock_q[dec_addr] <= stock_q[dec_addr] - STOCK_W'(1);
            end
        end
    end

    assign rd_valid = valid_q[rd_addr];
    assign rd_price = price_q[rd_addr];
    assign rd_stock = stock_q[rd_addr];

endmodule

// File: rtl/seletor_produto_estoque.sv
// Stocked product selector: latches a {linha,coluna} request, looks the slot
// up one cycle later, then offers (sel_valid, valor, codeOut, existe) until
// pay_ok (vend pulse, stock decrement) or cancel, or rejects (sel_reject,
// sold_out). cfg_* rewrites a slot while idle; busy flags dropped requests.
// Optional macro SEL_TIMEOUT_EN: abandon an unanswered offer after TIMEOUT_CYC
// cycles with a timeout pulse; without it the offer waits and timeout is 0.
module seletor_produto_estoque
    import seletor_pkg::*;
#(
    parameter int ROW_W       = 2,
    parameter int COL_W       = 2,
    parameter int PRICE_W     = 3,
    parameter int STOCK_W     = 4,
    parameter int INIT_STOCK  = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sel_req,
    input  logic [ROW_W-1:0]         linha,
    input  logic [COL_W-1:0]         coluna,
    input  logic                     pay_ok,
    input  logic                     cancel,
    input  logic                     cfg_we,
    input  logic [ROW_W+COL_W-1:0]   cfg_addr,
    input  logic                     cfg_valid,
    input  logic [PRICE_W-1:0]       cfg_price,
    input  logic [STOCK_W-1:0]       cfg_stock,
    output logic [PRICE_W-1:0]       valor,
    output logic [ROW_W+COL_W-1:0]   codeOut,
    output logic                     existe,
    output logic                     sel_valid,
    output logic                     sel_reject,
    output logic                     sold_out,
    output logic                     vend,
    output logic                     busy,
    output logic                     timeout
);

    localparam int CODE_W = ROW_W + COL_W;
    localparam logic [CODE_W-1:0] INV_CODE = CODE_W'(invalid_code(CODE_W));

    state_t              state;
    logic [CODE_W-1:0]   code_q;
    logic                rd_valid;
    logic [PRICE_W-1:0]  rd_price;
    logic [STOCK_W-1:0]  rd_stock;

    seletor_tabela #(
        .CODE_W     (CODE_W),
        .PRICE_W    (PRICE_W),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_tabela (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cfg_we && (state == ST_IDLE)),
        .wr_addr  (cfg_addr),
        .wr_valid (cfg_valid),
        .wr_price (cfg_price),
        .wr_stock (cfg_stock),
        .dec_en   (state == ST_VEND),
        .dec_addr (code_q),
        .rd_addr  (code_q),
        .rd_valid (rd_valid),
        .rd_price (rd_price),
        .rd_stock (rd_stock)
    );

    assign busy = (state != ST_IDLE);

`ifdef SEL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            code_q     <= '0;
            valor      <= '0;
            codeOut    <= INV_CODE;
            existe     <= 1'b0;
            sel_valid  <= 1'b0;
            sel_reject <= 1'b0;
            sold_out   <= 1'b0;
            vend       <= 1'b0;
`ifdef SEL_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            sel_reject <= 1'b0;
            vend       <= 1'b0;
`ifdef SEL_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (sel_req) begin
                        code_q <= {linha, coluna};
                        state  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (!rd_valid) begin
                        state      <= ST_REJECT;
                        sel_reject <= 1'b1;
                        existe     <= 1'b0;
                        codeOut    <= INV_CODE;
                        valor      <= '0;
                        sold_out   <= 1'b0;
                    end else if (rd_stock == '0) begin
                        state      <= ST_REJECT;
                        sel_reject <= 1'b1;
                        existe     <= 1'b1;
                        codeOut    <= code_q;
                        valor      <= rd_price;
                        sold_out   <= 1'b1;
                    end else begin
                        state      <= ST_OFFER;
                        existe     <= 1'b1;
                        codeOut    <= code_q;
                        valor      <= rd_price;
                        sel_valid  <= 1'b1;
`ifdef SEL_TIMEOUT_EN
                        cnt_q      <= '0;
`endif
                    end
                end
                ST_OFFER: begin
                    // pay_ok outranks both cancel and an expiring timer.
                    if (pay_ok) begin
                        state     <= ST_VEND;
                        vend      <= 1'b1;
                        sel_valid <= 1'b0;
                    end else if (cancel) begin
                        state     <= ST_IDLE;
                        sel_valid <= 1'b0;
                        existe    <= 1'b0;
                        codeOut   <= INV_CODE;
                        valor     <= '0;
                    end
`ifdef SEL_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state     <= ST_IDLE;
                        timeout_q <= 1'b1;
                        sel_valid <= 1'b0;
                        existe    <= 1'b0;
                        codeOut   <= INV_CODE;
                        valor     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    // VEND and REJECT last one cycle; stock drops on this edge in VEND.
                    state     <= ST_IDLE;
                    sel_valid <= 1'b0;
                    existe    <= 1'b0;
                    codeOut   <= INV_CODE;
                    valor     <= '0;
                    sold_out  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seletor_produto_estoque.sv
// Scoreboard bench for seletor_produto_estoque: stimulus pushes expected
// offer/reject/vend/timeout events, a negedge monitor pops and compares them.
module tb_seletor_produto_estoque;

    localparam int ROW_W = 2, COL_W = 2, PRICE_W = 3, STOCK_W = 4, INIT_STOCK = 4;
`ifdef SEL_TIMEOUT_EN
    localparam int TO_CYC = 5;
`else
    localparam int TO_CYC = 1000;
`endif

    logic clk = 1'b0;
    logic rst;
    logic sel_req, pay_ok, cancel, cfg_we, cfg_valid;
    logic [ROW_W-1:0] linha;
    logic [COL_W-1:0] coluna;
    logic [3:0] cfg_addr;
    logic [PRICE_W-1:0] cfg_price;
    logic [STOCK_W-1:0] cfg_stock;
    logic [PRICE_W-1:0] valor;
    logic [3:0] codeOut;
    logic existe, sel_valid, sel_reject, sold_out, vend, busy, timeout;

    always #5 clk = ~clk;

    seletor_produto_estoque #(
        .ROW_W(ROW_W), .COL_W(COL_W), .PRICE_W(PRICE_W), .STOCK_W(STOCK_W),
        .INIT_STOCK(INIT_STOCK), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst), .sel_req(sel_req), .linha(linha), .coluna(coluna),
        .pay_ok(pay_ok), .cancel(cancel), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_valid(cfg_valid), .cfg_price(cfg_price), .cfg_stock(cfg_stock),
        .valor(valor), .codeOut(codeOut), .existe(existe), .sel_valid(sel_valid),
        .sel_reject(sel_reject), .sold_out(sold_out), .vend(vend), .busy(busy),
        .timeout(timeout)
    );

    typedef enum int {EV_OFFER, EV_REJECT, EV_VEND, EV_TIMEOUT} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [3:0] code;
        logic [2:0] valor;
        logic       existe;
        logic       sold;
    } ev_t;

    ev_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Expected-event helpers
    function automatic void exp_offer(input logic [3:0] c, input logic [2:0] p);
        sb.push_back('{EV_OFFER, c, p, 1'b1, 1'b0});
    endfunction
    function automatic void exp_reject_inv();
        sb.push_back('{EV_REJECT, 4'hF, 3'd0, 1'b0, 1'b0});
    endfunction
    function automatic void exp_soldout(input logic [3:0] c, input logic [2:0] p);
        sb.push_back('{EV_REJECT, c, p, 1'b1, 1'b1});
    endfunction
    function automatic void exp_vend();
        sb.push_back('{EV_VEND, 4'h0, 3'd0, 1'b0, 1'b0});
    endfunction
    function automatic void exp_timeout();
        sb.push_back('{EV_TIMEOUT, 4'h0, 3'd0, 1'b0, 1'b0});
    endfunction

    // Monitor
    task automatic take(input ev_kind_t k);
        if (sb.size() == 0) begin
            fail_now("unexpected_event", $sformatf("got event kind %0d, expected none", k));
        end else begin
            ev_t e;
            e = sb.pop_front();
            chk("event_kind", k, e.kind);
            if (k == EV_OFFER || k == EV_REJECT) begin
                chk("codeOut", codeOut, e.code);
                chk("valor", valor, e.valor);
                chk("existe", existe, e.existe);
                chk("sold_out", sold_out, e.sold);
            end
        end
    endtask

    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sel_valid && !prev_valid) take(EV_OFFER);
                if (sel_reject) take(EV_REJECT);
                if (vend) take(EV_VEND);
                if (timeout) take(EV_TIMEOUT);
            end
            prev_valid = sel_valid;
        end
    end

    // Stimulus tasks: all start and end on a falling edge.
    task automatic req(input logic [3:0] c);
        sel_req = 1'b1;
        linha   = c[3:2];
        coluna  = c[1:0];
        @(negedge clk);
        sel_req = 1'b0;
    endtask

    task automatic cfg(input logic [3:0] a, input logic v, input logic [2:0] p, input logic [3:0] s);
        cfg_we = 1'b1; cfg_addr = a; cfg_valid = v; cfg_price = p; cfg_stock = s;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_resp(input string name);
        int n;
        n = 0;
        while (!(sel_valid || sel_reject) && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!(sel_valid || sel_reject)) fail_now(name, "no offer/reject within 8 cycles");
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_now(name, "busy still 1 after 10 cycles");
    endtask

    task automatic pay();
        pay_ok = 1'b1;
        @(negedge clk);
        pay_ok = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
    endtask

    task automatic buy(input logic [3:0] c, input logic [2:0] p);
        exp_offer(c, p);
        exp_vend();
        req(c);
        wait_resp("buy_resp");
        pay();
        wait_idle("buy_idle");
    endtask

    task automatic expect_soldout(input logic [3:0] c, input logic [2:0] p);
        exp_soldout(c, p);
        req(c);
        wait_resp("soldout_resp");
        wait_idle("soldout_idle");
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valor"}, valor, 0);
        chk({tag, "_codeOut"}, codeOut, 4'hF);
        chk({tag, "_existe"}, existe, 0);
        chk({tag, "_sel_valid"}, sel_valid, 0);
        chk({tag, "_sel_reject"}, sel_reject, 0);
        chk({tag, "_sold_out"}, sold_out, 0);
        chk({tag, "_vend"}, vend, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; sel_req = 0; pay_ok = 0; cancel = 0; cfg_we = 0; cfg_valid = 0;
        linha = 0; coluna = 0; cfg_addr = 0; cfg_price = 0; cfg_stock = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset("reset");

        // Code 0100 price 6: four vends drain stock 4, fifth is sold out.
        for (int i = 0; i < 4; i++) buy(4'b0100, 3'd6);
        expect_soldout(4'b0100, 3'd6);

        // Unmapped code 0001
        exp_reject_inv();
        req(4'b0001);
        wait_resp("unmapped_resp");
        wait_idle("unmapped_idle");
        chk("unmapped_back_idle", busy, 0);

        // Code 1000 price 1: drain, then restock to 2 via config.
        for (int i = 0; i < 4; i++) buy(4'b1000, 3'd1);
        expect_soldout(4'b1000, 3'd1);
        cfg(4'b1000, 1'b1, 3'd1, 4'd2);
        buy(4'b1000, 3'd1);
        buy(4'b1000, 3'd1);
        expect_soldout(4'b1000, 3'd1);

        // pay_ok and cancel together: pay wins.
        exp_offer(4'b0101, 3'd1);
        exp_vend();
        req(4'b0101);
        wait_resp("paycancel_resp");
        pay_ok = 1'b1; cancel = 1'b1;
        @(negedge clk);
        pay_ok = 1'b0; cancel = 1'b0;
        wait_idle("paycancel_idle");

        // Cancel alone leaves stock intact (stock 1 still sells once after cancel).
        cfg(4'b1101, 1'b1, 3'd5, 4'd1);
        exp_offer(4'b1101, 3'd5);
        req(4'b1101);
        wait_resp("cancel_resp");
        do_cancel();
        wait_idle("cancel_idle");
        chk("cancel_sel_valid", sel_valid, 0);
        buy(4'b1101, 3'd5);
        expect_soldout(4'b1101, 3'd5);

        // sel_req and cfg_we while busy are dropped.
        exp_offer(4'b1010, 3'd5);
        exp_vend();
        req(4'b1010);
        wait_resp("busy_resp");
        sel_req = 1'b1; linha = 2'b00; coluna = 2'b00;
        cfg_we = 1'b1; cfg_addr = 4'b1010; cfg_valid = 1'b0; cfg_price = 3'd7; cfg_stock = 4'd0;
        @(negedge clk);
        sel_req = 1'b0; cfg_we = 1'b0;
        chk("busy_during_offer", busy, 1);
        chk("offer_held_valid", sel_valid, 1);
        chk("offer_held_valor", valor, 5);
        pay();
        wait_idle("busy_idle");
        buy(4'b1010, 3'd5);

        // pay_ok in IDLE is ignored (monitor flags any stray vend).
        pay();
        chk("idle_pay_ignored", busy, 0);

        // Same-cycle cfg write and request: lookup sees the new slot.
        exp_offer(4'b0011, 3'd7);
        sel_req = 1'b1; linha = 2'b00; coluna = 2'b11;
        cfg_we = 1'b1; cfg_addr = 4'b0011; cfg_valid = 1'b1; cfg_price = 3'd7; cfg_stock = 4'd1;
        @(negedge clk);
        sel_req = 1'b0; cfg_we = 1'b0;
        wait_resp("samecycle_resp");
        do_cancel();
        wait_idle("samecycle_idle");

        // Reset in OFFER: outputs and tables return to defaults.
        exp_offer(4'b0000, 3'd2);
        req(4'b0000);
        wait_resp("rstmid_resp");
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_vend", vend, 0);
        buy(4'b0100, 3'd6);
        for (int i = 0; i < 4; i++) buy(4'b1000, 3'd1);
        expect_soldout(4'b1000, 3'd1);
        exp_reject_inv();
        req(4'b0011);
        wait_resp("rstmid_cfg_gone");
        wait_idle("rstmid_cfg_idle");

`ifdef SEL_TIMEOUT_EN
        exp_offer(4'b1100, 3'd2);
        exp_timeout();
        req(4'b1100);
        wait_resp("timeout_resp");
        n = 0;
        while (sel_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_offer_cycles", n, 5);
        chk("timeout_idle", busy, 0);
        for (int i = 0; i < 4; i++) buy(4'b1100, 3'd2);
        expect_soldout(4'b1100, 3'd2);
`else
        exp_offer(4'b1100, 3'd2);
        req(4'b1100);
        wait_resp("hold_resp");
        n = 0;
        repeat (20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_sel_valid", sel_valid, 1);
        chk("hold_busy", busy, 1);
        do_cancel();
        wait_idle("hold_idle");
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
